reg_snapshot_scheduler: RTL and testbench
=========================================

# reg_snapshot_scheduler

Sequencer that owns the RISC-V register file's single shared read port on behalf of the VGA register debug display. On each frame tick it sweeps x0..x31 through the read port in cycles the CPU leaves free, and maintains a shadow copy (`snap_regs`) plus a `changed_mask` highlight mask with a timed decay. It sits between the core's register file and `risc_debug_display`, replacing free-running demo register values with live, frame-coherent snapshots.

## Interface
- `NUM_REGS`, default 32: registers swept; index width is fixed at 5 bits.
- `DATA_W`, default 32: register width.
- `HOLD_SCANS`, default 60: completed scans with no change before `changed_mask` clears; about 1 s at 60 Hz.
- `clock`  in  1: system clock (50 MHz); the only clock.
- `sw0_n`  in  1: reset, asynchronous assert, active-low.
- `vsync_tick`  in  1: one-cycle pulse at the frame boundary; requests a sweep.
- `freeze`  in  1: level; when high, no new sweep starts and the hold counter is frozen.
- `cpu_rd_req`  in  1: CPU uses the read port this cycle; absolute priority.
- `cpu_rd_addr`  in  5: CPU read address.
- `rf_rd_addr`  out  5: shared read-port address (combinational mux).
- `rf_rd_data`  in  DATA_W: read data; valid exactly 1 cycle after the address.
- `snap_regs`  out  [0:NUM_REGS-1][DATA_W]: shadow register values.
- `changed_mask`  out  NUM_REGS: bit i = x_i changed during a recent scan.
- `scan_done`  out  1: one-cycle pulse when a sweep completes.
- `scan_overrun`  out  1: one-cycle pulse when `vsync_tick` arrives while not IDLE.

## Operation
- FSM states and transitions:
  - IDLE -> SCAN when `vsync_tick` is high and `freeze` is low.
  - SCAN -> DRAIN after index 31 is issued.
  - DRAIN -> DONE after the last data is captured.
  - DONE -> IDLE unconditionally.
- Arbitration:
  - If `cpu_rd_req` is high, `rf_rd_addr` = `cpu_rd_addr`, no scan issue occurs, and `scan_idx` holds.
  - Otherwise `rf_rd_addr` = `scan_idx` in SCAN, and 0 in all other states.
- Issue tracking:
  - An issue in SCAN sets a 1-cycle `pend` flag with a captured index `pidx`, then increments `scan_idx`.
  - The cycle after an issue, `rf_rd_data` is compared with `snap_regs[pidx]`.
  - CPU-granted reads never set `pend`, so their data is never captured.
- Capture: on a pending return, `snap_regs[pidx]` <= `rf_rd_data`. If the value differs and `primed` is 1, `changed_mask[pidx]` <= 1 and `chg_seen` <= 1.
- `primed`: cleared by reset, set in DONE. The first sweep after reset fills the shadow without highlighting.
- Hold counter (width clog2(HOLD_SCANS+1)), updated in DONE:
  - If `chg_seen`, load HOLD_SCANS.
  - Else if hold > 0, decrement; on the 1 -> 0 transition, clear `changed_mask`.
  - Clear `chg_seen` in DONE.
- `freeze` raised mid-sweep: the sweep still completes. The hold counter is not updated in DONE while `freeze` is high.
- `vsync_tick` in SCAN, DRAIN or DONE: ignored; pulse `scan_overrun` in the following cycle.
- `snap_regs` updates register-by-register during a sweep. It is coherent only between `scan_done` and the next SCAN.

## Timing
- Reset values:
  - All outputs 0: `snap_regs` all zero, `changed_mask` = 0, `scan_done` = 0, `scan_overrun` = 0.
  - `rf_rd_addr` = `cpu_rd_addr` if `cpu_rd_req`, else 0.
  - Internal: state IDLE, `scan_idx` = 0, `pend` = 0, hold = 0, `primed` = 0.
- Uncontended sweep, with tick high in cycle T:
  - Issues occur in cycles T+1..T+32.
  - Data for index k is captured at the end of cycle T+2+k.
  - DRAIN is cycle T+33; `scan_done` is high in cycle T+34 (DONE).
  - Latency 34 cycles.
- Each CPU-granted cycle during SCAN adds exactly 1 cycle to the sweep. There is no timeout; a CPU that holds the port permanently stalls the sweep indefinitely.
- `cpu_rd_req` in the cycle after an issue does not disturb that capture, because `pend` is independent of the grant.
- `sw0_n` asserted mid-sweep: immediate return to the reset state. The next sweep after release is unprimed.

## Test plan
- **Reset then sweep.** Reset, register file loaded with x_i = i*0x11111111, then one tick. Required: `scan_done` at T+34, `snap_regs[5]` = 0x55555555, `changed_mask` = 0 (unprimed).
- **Single change highlighted.** After priming, x10 goes 0xAAAABBBB -> 0xAAAABBBC, then tick. Required: `changed_mask` = 0x00000400 after that sweep. With no further changes, the mask stays set through sweeps 1..59 and clears at the 60th `scan_done`.
- **CPU contention.** `cpu_rd_req` high for 10 cycles starting at T+5, with `cpu_rd_addr` = 3. Required: `rf_rd_addr` = 3 during those cycles, no capture of the CPU data, `scan_done` at T+44, all 32 shadows correct.
- **Overrun.** Second tick at T+20. Required: `scan_overrun` pulse at T+21, sweep unaffected, single `scan_done` at T+34.
- **Freeze.** `freeze` high before the tick: no sweep and `snap_regs` unchanged. `freeze` raised at T+10: sweep completes at T+34 and the hold counter is unchanged.
- **Reset mid-sweep.** `sw0_n` low at T+15. Required: all outputs 0 immediately. After release and a tick, the next sweep leaves `changed_mask` = 0.

Source files
------------

// File: rtl/reg_snapshot_scheduler_if.sv
// Shared register-file read port: CPU request side plus the muxed address
// and the returning data. The scheduler owns the mux (master); the core /
// register file side (slave) supplies the CPU request and the read data.
interface reg_snapshot_scheduler_if #(
  parameter int DATA_W = 32
);
  logic              cpu_rd_req;
  logic [4:0]        cpu_rd_addr;
  logic [4:0]        rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;

  modport master (
    input  cpu_rd_req, cpu_rd_addr, rf_rd_data,
    output rf_rd_addr
  );

  modport slave (
    output cpu_rd_req, cpu_rd_addr, rf_rd_data,
    input  rf_rd_addr
  );
endinterface

// File: rtl/reg_snapshot_scheduler.sv
// Frame-synchronous register-file sweeper for the VGA debug display.
// Steals idle read-port cycles to copy x0..x(NUM_REGS-1) into a shadow,
// flags registers that changed and lets the highlight decay after
// HOLD_SCANS quiet sweeps.
module reg_snapshot_scheduler #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_W     = 32,
  parameter int HOLD_SCANS = 60
) (
  input  logic                                clock,
  input  logic                                sw0_n,
  input  logic                                vsync_tick,
  input  logic                                freeze,
  reg_snapshot_scheduler_if.master            bus,
  output logic [0:NUM_REGS-1][DATA_W-1:0]     snap_regs,
  output logic [NUM_REGS-1:0]                 changed_mask,
  output logic                                scan_done,
  output logic                                scan_overrun
);

  localparam int              HW       = $clog2(HOLD_SCANS + 1);
  localparam logic [4:0]      LAST_IDX = 5'(NUM_REGS - 1);
  localparam logic [HW-1:0]   HOLD_LD  = HW'(HOLD_SCANS);
  localparam logic [HW-1:0]   HOLD_ONE = HW'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t        state, state_nx;
  logic [4:0]    scan_idx;
  logic [4:0]    pidx;
  logic          pend;
  logic          primed;
  logic          chg_seen;
  logic [HW-1:0] hold;
  logic          issue;

  // State register
  always_ff @(posedge clock or negedge sw0_n) begin
    if (!sw0_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: sweep on tick, drain the last read, one DONE cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (vsync_tick && !freeze)           state_nx = SCAN;
      SCAN:    if (issue && scan_idx == LAST_IDX)   state_nx = DRAIN;
      DRAIN:                                        state_nx = DONE;
      DONE:                                         state_nx = IDLE;
      default:                                      state_nx = IDLE;
    endcase
  end

  // Outputs: CPU always wins the port; the sweep only issues on free cycles
  always_comb begin
    issue     = (state == SCAN) && !bus.cpu_rd_req;
    scan_done = (state == DONE);
    if (bus.cpu_rd_req)     bus.rf_rd_addr = bus.cpu_rd_addr;
    else if (state == SCAN) bus.rf_rd_addr = scan_idx;
    else                    bus.rf_rd_addr = 5'd0;
  end

  // Sweep datapath: issue tracking, shadow capture, highlight and decay
  always_ff @(posedge clock or negedge sw0_n) begin
    if (!sw0_n) begin
      scan_idx     <= '0;
      pidx         <= '0;
      pend         <= 1'b0;
      primed       <= 1'b0;
      chg_seen     <= 1'b0;
      hold         <= '0;
      snap_regs    <= '0;
      changed_mask <= '0;
      scan_overrun <= 1'b0;
    end else begin
      // pend tracks only our own issues, so a CPU grant right after an
      // issue cannot corrupt the capture
      pend <= issue;
      if (issue) begin
        pidx     <= scan_idx;
        scan_idx <= (scan_idx == LAST_IDX) ? 5'd0 : scan_idx + 5'd1;
      end else if (state != SCAN) begin
        scan_idx <= '0;
      end

      // First sweep after reset only fills the shadow
      if (pend) begin
        snap_regs[pidx] <= bus.rf_rd_data;
        if (primed && bus.rf_rd_data != snap_regs[pidx]) begin
          changed_mask[pidx] <= 1'b1;
          chg_seen           <= 1'b1;
        end
      end

      // A frozen DONE leaves the decay (and any pending change) untouched
      if (state == DONE) begin
        primed <= 1'b1;
        if (!freeze) begin
          chg_seen <= 1'b0;
          if (chg_seen) begin
            hold <= HOLD_LD;
          end else if (hold != '0) begin
            hold <= hold - HOLD_ONE;
            if (hold == HOLD_ONE) changed_mask <= '0;
          end
        end
      end

      scan_overrun <= vsync_tick && (state != IDLE);
    end
  end

endmodule

// File: tb/tb_reg_snapshot_scheduler.sv
// Scoreboard bench: a sweep-level model computes the expected shadow/mask
// and completion cycle when each tick is driven; a monitor pops and
// compares when scan_done appears.
module tb_reg_snapshot_scheduler;
  localparam int NR   = 32;
  localparam int DW   = 32;
  localparam int HOLD = 60;

  typedef struct packed {
    logic [31:0]            done_cyc;
    logic [31:0]            mask;
    logic [0:NR-1][DW-1:0]  sh;
  } exp_t;

  logic clock = 1'b0;
  logic sw0_n, vsync_tick, freeze;
  logic [0:NR-1][DW-1:0] snap_regs;
  logic [NR-1:0]         changed_mask;
  logic                  scan_done, scan_overrun;

  reg_snapshot_scheduler_if #(.DATA_W(DW)) bus ();

  reg_snapshot_scheduler #(.NUM_REGS(NR), .DATA_W(DW), .HOLD_SCANS(HOLD)) dut (
    .clock        (clock),
    .sw0_n        (sw0_n),
    .vsync_tick   (vsync_tick),
    .freeze       (freeze),
    .bus          (bus),
    .snap_regs    (snap_regs),
    .changed_mask (changed_mask),
    .scan_done    (scan_done),
    .scan_overrun (scan_overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // register file model: data valid one cycle after the address
  logic [DW-1:0] rf [NR];
  always @(posedge clock) bus.rf_rd_data <= rf[bus.rf_rd_addr];

  int n_chk = 0;
  int n_pass = 0;
  exp_t q[$];

  // sweep-level reference model state
  logic [DW-1:0] m_sh [NR];
  logic [NR-1:0] m_mask;
  int            m_hold;
  bit            m_chg, m_primed;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_sh[i] = '0;
    m_mask = '0; m_hold = 0; m_chg = 0; m_primed = 0;
  endtask

  task automatic model_sweep(input bit fz, output exp_t e);
    bit chg = 0;
    for (int i = 0; i < NR; i++) begin
      if (rf[i] != m_sh[i]) begin
        if (m_primed) begin m_mask[i] = 1'b1; chg = 1; end
        m_sh[i] = rf[i];
      end
    end
    m_chg = m_chg | chg;
    if (!fz) begin
      if (m_chg) m_hold = HOLD;
      else if (m_hold > 0) begin
        m_hold--;
        if (m_hold == 0) m_mask = '0;
      end
      m_chg = 0;
    end
    m_primed = 1;
    e.mask = m_mask;
    for (int i = 0; i < NR; i++) e.sh[i] = m_sh[i];
    e.done_cyc = '0;
  endtask

  // monitor: completion cycle in DONE, shadow and mask once DONE has settled
  exp_t me;
  always begin
    @(negedge clock);
    if (scan_done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        me = q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(me.done_cyc));
        @(negedge clock);
        for (int i = 0; i < NR; i++) chk($sformatf("snap[%0d]", i), 64'(snap_regs[i]), 64'(me.sh[i]));
        chk("changed_mask", 64'(changed_mask), 64'(me.mask));
      end
    end
  end

  // one sweep: tick at T, optional CPU window / second tick / late freeze
  task automatic sweep(input int cpu_s, input int cpu_n, input int ovr_at, input int frz_at);
    exp_t e;
    int t0, lat;
    model_sweep(frz_at >= 0, e);
    @(posedge clock); #1;
    vsync_tick = 1'b1;
    t0  = cyc;
    lat = 34 + cpu_n;
    e.done_cyc = 32'(t0 + lat);
    q.push_back(e);
    for (int k = 1; k <= lat + 2; k++) begin
      @(posedge clock); #1;
      vsync_tick  = (k == ovr_at);
      cpu_rd_req_drive(k >= cpu_s && k < cpu_s + cpu_n);
      if (frz_at >= 0 && k >= frz_at) freeze = 1'b1;
      @(negedge clock);
      if (bus.cpu_rd_req) chk("cpu_addr", 64'(bus.rf_rd_addr), 64'd3);
      if (ovr_at > 0 && (k == ovr_at || k == ovr_at + 2)) chk("overrun_idle", 64'(scan_overrun), 0);
      if (ovr_at > 0 && k == ovr_at + 1) chk("overrun_pulse", 64'(scan_overrun), 1);
    end
    vsync_tick = 1'b0; freeze = 1'b0; cpu_rd_req_drive(1'b0);
    chk("sweep_finished", 64'(q.size()), 0);
    q.delete();
  endtask

  task automatic cpu_rd_req_drive(input bit v);
    bus.cpu_rd_req  = v;
    bus.cpu_rd_addr = 5'd3;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: cycle %0d reached without finishing", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    sw0_n = 1'b0; vsync_tick = 1'b0; freeze = 1'b0;
    bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 5'd7;
    for (int i = 0; i < NR; i++) rf[i] = 32'(i) * 32'h1111_1111;
    model_reset();
    #3;
    // reset state
    chk("rst_cpu_addr", 64'(bus.rf_rd_addr), 7);
    chk("rst_snap", 64'(|snap_regs), 0);
    chk("rst_mask", 64'(changed_mask), 0);
    chk("rst_done", 64'(scan_done), 0);
    chk("rst_overrun", 64'(scan_overrun), 0);
    bus.cpu_rd_req = 1'b0;
    #1;
    chk("rst_idle_addr", 64'(bus.rf_rd_addr), 0);
    repeat (3) @(posedge clock);
    #1 sw0_n = 1'b1;
    repeat (2) @(posedge clock);

    // unprimed fill, then overrun, then CPU contention
    sweep(0, 0, 0, -1);
    chk("snap5", 64'(snap_regs[5]), 64'h5555_5555);
    sweep(0, 0, 20, -1);
    sweep(5, 10, 0, -1);

    // freeze before tick: no sweep, shadow untouched
    rf[2] = 32'hDEAD_0002;
    @(posedge clock); #1 freeze = 1'b1; vsync_tick = 1'b1;
    @(posedge clock); #1 vsync_tick = 1'b0;
    repeat (40) @(posedge clock);
    @(negedge clock);
    chk("frozen_snap2", 64'(snap_regs[2]), 64'(m_sh[2]));
    freeze = 1'b0;
    rf[2] = 32'h2222_2222;

    // single change highlight and decay over HOLD sweeps
    rf[10] = 32'hAAAA_BBBB;
    sweep(0, 0, 0, -1);
    rf[10] = 32'hAAAA_BBBC;
    sweep(0, 0, 0, -1);
    chk("mask_x10", 64'(changed_mask), 64'h0000_0400);
    for (int s = 0; s < HOLD; s++) sweep(0, 0, 0, -1);
    chk("mask_cleared", 64'(changed_mask), 0);

    // freeze raised mid-sweep holds the decay counter
    rf[10] = 32'h1234_5678;
    sweep(0, 0, 0, -1);
    for (int s = 0; s < HOLD - 2; s++) sweep(0, 0, 0, -1);
    sweep(0, 0, 0, 10);
    sweep(0, 0, 0, -1);
    chk("mask_after_freeze", 64'(changed_mask), 64'h0000_0400);
    sweep(0, 0, 0, -1);

    // reset mid-sweep
    rf[4] = 32'h4444_0000;
    sweep(0, 0, 0, -1);
    chk("mask_x4", 64'(changed_mask), 64'h0000_0010);
    rf[6] = 32'h6666_0000;
    @(posedge clock); #1 vsync_tick = 1'b1;
    @(posedge clock); #1 vsync_tick = 1'b0;
    repeat (14) @(posedge clock);
    #1 sw0_n = 1'b0;
    #1;
    chk("mid_rst_snap", 64'(|snap_regs), 0);
    chk("mid_rst_mask", 64'(changed_mask), 0);
    chk("mid_rst_done", 64'(scan_done), 0);
    chk("mid_rst_overrun", 64'(scan_overrun), 0);
    chk("mid_rst_addr", 64'(bus.rf_rd_addr), 0);
    repeat (3) @(posedge clock);
    #1 sw0_n = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    sweep(0, 0, 0, -1);
    chk("unprimed_mask", 64'(changed_mask), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
